idecode: RTL and testbench
==========================

IDECODE -- requirements
Module: idecode

Interface
REQ-001 SHALL have parameter NOP_INST, default 32'h0000_0000, meaning the bubble instruction encoding.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports inst_i  input  32  and inst_addr_i  input  16: the fetched instruction and its address, from ifetch.
REQ-005 SHALL have ports stall_i  input  1  (execute cannot accept) and flush_i  input  1  (branch taken in execute; discard decode contents).
REQ-006 SHALL have ports wb_we_i  input  1, wb_addr_i  input  5, wb_data_i  input  32: writeback port into the register file.
REQ-007 SHALL have port stall_o  output  1  hold request to ifetch, driving its stall_i.
REQ-008 SHALL have outputs valid_o 1, op_o 6, rd_o 5, rs_data_o 32, rt_data_o 32, imm_o 32, pc_o 16, reg_write_o 1, mem_read_o 1, mem_write_o 1, branch_o 1: the registered execute-stage bundle.

Function
REQ-009 SHALL decode inst_i fields as op=[31:26], rd=[25:21], rs=[20:16], rt=[15:11], imm16=[15:0].
REQ-010 SHALL classify op: 6'h00 NOP; 6'h01-6'h0F ALU-reg (uses rs, rt; reg_write); 6'h10-6'h1F ALU-imm (uses rs; reg_write); 6'h20 LD (uses rs; mem_read, reg_write); 6'h21 ST (uses rs, rt; mem_write); 6'h30 BEQ (uses rs, rt; branch); 6'h31 JMP (branch); all other ops are illegal and SHALL be issued as a bubble.
REQ-011 SHALL sign-extend imm16 to imm_o, except JMP, which zero-extends.
REQ-012 SHALL hold 32 x 32-bit registers; r0 SHALL always read 0 and writes to r0 SHALL be ignored.
REQ-013 SHALL read rs/rt combinationally from inst_i and bypass wb_data_i when wb_we_i=1 and wb_addr_i matches a nonzero read address in the same cycle.
REQ-014 SHALL register the decoded bundle on the rising edge, giving 1-cycle latency from inst_i/inst_addr_i to outputs, with pc_o=inst_addr_i.
REQ-015 SHALL detect load-use when valid_o=1, mem_read_o=1, rd_o!=0, and rd_o equals a source register that inst_i uses.
REQ-016 SHALL, on load-use, drive stall_o=1 combinationally and load a bubble next cycle; inst_i SHALL be re-presented by ifetch and decoded the following cycle.
REQ-017 SHALL, when stall_i=1, hold all outputs unchanged and drive stall_o=1.
REQ-018 SHALL, when flush_i=1, load a bubble and drive stall_o=0, regardless of stall_i and load-use.
REQ-019 SHALL apply priority rst > flush_i > stall_i > load-use > normal issue.
REQ-020 SHALL define a bubble as valid_o=0 with reg_write_o, mem_read_o, mem_write_o and branch_o all 0; op_o=NOP_INST[31:26]; other fields don't-care.
REQ-021 SHALL update the register file from the writeback port even while stalled or flushed.

Reset
REQ-022 SHALL, while rst=1 at a clock edge, load a bubble, set pc_o=16'h0000, rd_o=0, rs_data_o=rt_data_o=imm_o=0 and stall_o=0.
REQ-023 SHALL clear all 32 registers to 0 on reset; a writeback in the same cycle as reset SHALL be dropped.
REQ-024 SHALL drive stall_o=0 combinationally while rst=1, including reset asserted mid-stall.

Structure
REQ-025 SHALL place opcode constants, field bit positions and the NOP encoding in a shared package/include used by ifetch, idecode and execute.
REQ-026 SHALL instantiate the register file as one sub-module, regfile32x32: two combinational read ports with bypass, one synchronous write port.

Verification
REQ-027 SHALL verify reset: hold rst=1 for 2 cycles with inst_i=32'h0421_0000 -> valid_o=0, pc_o=0, stall_o=0; all registers read 0.
REQ-028 SHALL verify ALU-imm: r2 preloaded to 5 via wb, inst_i=6'h10/rd=3/rs=2/imm=16'hFFFF, addr 16'h0004 -> next cycle valid_o=1, rs_data_o=5, imm_o=32'hFFFF_FFFF, pc_o=16'h0004, reg_write_o=1.
REQ-029 SHALL verify load-use: LD rd=4, then ALU-reg with rs=4 -> stall_o=1 for exactly 1 cycle, one bubble, then the ALU-reg is issued with pc unchanged.
REQ-030 SHALL verify bypass: wb_we_i=1, wb_addr_i=7, wb_data_i=32'hDEAD_BEEF, same cycle as inst_i reading rs=7 -> rs_data_o=32'hDEAD_BEEF; also confirm a write to r0 reads back 0.
REQ-031 SHALL verify flush vs stall: flush_i=1 together with stall_i=1 and a pending load-use -> valid_o=0, stall_o=0 next cycle.
REQ-032 SHALL verify illegal op and stall hold: op=6'h3F -> bubble issued; stall_i=1 for 3 cycles -> outputs frozen, stall_o=1 throughout.

Source files
------------

// File: rtl/idecode_pkg.sv
// Shared instruction-format definitions for ifetch, idecode and execute.
// Holds opcode values, field bit positions, the bubble encoding and decode helpers.
package idecode_pkg;

    localparam logic [31:0] NOP_ENCODING = 32'h0000_0000;

    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned RD_MSB  = 25;
    localparam int unsigned RD_LSB  = 21;
    localparam int unsigned RS_MSB  = 20;
    localparam int unsigned RS_LSB  = 16;
    localparam int unsigned RT_MSB  = 15;
    localparam int unsigned RT_LSB  = 11;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [5:0] OP_NOP     = 6'h00;
    localparam logic [5:0] OP_ALU_LO  = 6'h01;
    localparam logic [5:0] OP_ALU_HI  = 6'h0F;
    localparam logic [5:0] OP_ALUI_LO = 6'h10;
    localparam logic [5:0] OP_ALUI_HI = 6'h1F;
    localparam logic [5:0] OP_LD      = 6'h20;
    localparam logic [5:0] OP_ST      = 6'h21;
    localparam logic [5:0] OP_BEQ     = 6'h30;
    localparam logic [5:0] OP_JMP     = 6'h31;

    typedef enum logic [2:0] {
        ClsNop,
        ClsAluReg,
        ClsAluImm,
        ClsLd,
        ClsSt,
        ClsBeq,
        ClsJmp,
        ClsIllegal
    } op_class_e;

    typedef struct packed {
        logic issue;
        logic uses_rs;
        logic uses_rt;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic zero_ext;
    } ctrl_t;

    function automatic op_class_e classify(input logic [5:0] op);
        if (op == OP_NOP)                            return ClsNop;
        if (op >= OP_ALU_LO && op <= OP_ALU_HI)      return ClsAluReg;
        if (op >= OP_ALUI_LO && op <= OP_ALUI_HI)    return ClsAluImm;
        if (op == OP_LD)                             return ClsLd;
        if (op == OP_ST)                             return ClsSt;
        if (op == OP_BEQ)                            return ClsBeq;
        if (op == OP_JMP)                            return ClsJmp;
        return ClsIllegal;
    endfunction

    // NOP and illegal opcodes both leave issue=0 so they go out as bubbles.
    function automatic ctrl_t decode_ctrl(input op_class_e cls);
        ctrl_t c;
        c = '0;
        unique case (cls)
            ClsAluReg: begin c.issue = 1'b1; c.uses_rs = 1'b1; c.uses_rt = 1'b1;
                             c.reg_write = 1'b1; end
            ClsAluImm: begin c.issue = 1'b1; c.uses_rs = 1'b1; c.reg_write = 1'b1; end
            ClsLd:     begin c.issue = 1'b1; c.uses_rs = 1'b1; c.mem_read = 1'b1;
                             c.reg_write = 1'b1; end
            ClsSt:     begin c.issue = 1'b1; c.uses_rs = 1'b1; c.uses_rt = 1'b1;
                             c.mem_write = 1'b1; end
            ClsBeq:    begin c.issue = 1'b1; c.uses_rs = 1'b1; c.uses_rt = 1'b1;
                             c.branch = 1'b1; end
            ClsJmp:    begin c.issue = 1'b1; c.branch = 1'b1; c.zero_ext = 1'b1; end
            ClsNop, ClsIllegal: c = '0;
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/idecode_regfile32x32.sv
// 32x32 register file: two combinational read ports with writeback bypass,
// one synchronous write port; r0 is hardwired to zero.
module regfile32x32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b
);

    logic [31:0] mem [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr != 5'd0) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (raddr_a != 5'd0) begin
            rdata_a = (we && waddr == raddr_a) ? wdata : mem[raddr_a];
        end
        if (raddr_b != 5'd0) begin
            rdata_b = (we && waddr == raddr_b) ? wdata : mem[raddr_b];
        end
    end

endmodule

// File: rtl/idecode.sv
// Instruction decode stage: field decode, register read, load-use interlock
// and the registered bundle handed to execute.
module idecode
    import idecode_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_ENCODING
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [15:0] inst_addr_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    output logic        stall_o,
    output logic        valid_o,
    output logic [5:0]  op_o,
    output logic [4:0]  rd_o,
    output logic [31:0] rs_data_o,
    output logic [31:0] rt_data_o,
    output logic [31:0] imm_o,
    output logic [15:0] pc_o,
    output logic        reg_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        branch_o
);

    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm16;
    logic [31:0] imm_ext;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    ctrl_t       ctrl;
    logic        load_use;

    assign op    = inst_i[OP_MSB:OP_LSB];
    assign rd    = inst_i[RD_MSB:RD_LSB];
    assign rs    = inst_i[RS_MSB:RS_LSB];
    assign rt    = inst_i[RT_MSB:RT_LSB];
    assign imm16 = inst_i[IMM_MSB:IMM_LSB];
    assign ctrl  = decode_ctrl(classify(op));

    assign imm_ext = ctrl.zero_ext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};

    regfile32x32 u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_we_i),
        .waddr   (wb_addr_i),
        .wdata   (wb_data_i),
        .raddr_a (rs),
        .rdata_a (rs_data),
        .raddr_b (rt),
        .rdata_b (rt_data)
    );

    assign load_use = valid_o && mem_read_o && (rd_o != 5'd0) &&
                      ((ctrl.uses_rs && rs == rd_o) || (ctrl.uses_rt && rt == rd_o));

    assign stall_o = !rst && !flush_i && (stall_i || load_use);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o     <= 1'b0;
            op_o        <= NOP_INST[31:26];
            rd_o        <= '0;
            rs_data_o   <= '0;
            rt_data_o   <= '0;
            imm_o       <= '0;
            pc_o        <= '0;
            reg_write_o <= 1'b0;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            branch_o    <= 1'b0;
        end else if (flush_i || (!stall_i && (load_use || !ctrl.issue))) begin
            valid_o     <= 1'b0;
            op_o        <= NOP_INST[31:26];
            reg_write_o <= 1'b0;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            branch_o    <= 1'b0;
        end else if (!stall_i) begin
            valid_o     <= 1'b1;
            op_o        <= op;
            rd_o        <= rd;
            rs_data_o   <= rs_data;
            rt_data_o   <= rt_data;
            imm_o       <= imm_ext;
            pc_o        <= inst_addr_i;
            reg_write_o <= ctrl.reg_write;
            mem_read_o  <= ctrl.mem_read;
            mem_write_o <= ctrl.mem_write;
            branch_o    <= ctrl.branch;
        end
    end

endmodule

// File: tb/tb_idecode.sv
// Self-checking bench for idecode: a table of single-issue vectors plus
// hand-written reset, load-use, bypass, flush and stall sequences.
module tb_idecode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i;
    logic [15:0] inst_addr_i;
    logic        stall_i;
    logic        flush_i;
    logic        wb_we_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        stall_o;
    logic        valid_o;
    logic [5:0]  op_o;
    logic [4:0]  rd_o;
    logic [31:0] rs_data_o;
    logic [31:0] rt_data_o;
    logic [31:0] imm_o;
    logic [15:0] pc_o;
    logic        reg_write_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        branch_o;

    int checks = 0;
    int failures = 0;

    idecode #(.NOP_INST(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_i      (inst_i),
        .inst_addr_i (inst_addr_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .wb_we_i     (wb_we_i),
        .wb_addr_i   (wb_addr_i),
        .wb_data_i   (wb_data_i),
        .stall_o     (stall_o),
        .valid_o     (valid_o),
        .op_o        (op_o),
        .rd_o        (rd_o),
        .rs_data_o   (rs_data_o),
        .rt_data_o   (rt_data_o),
        .imm_o       (imm_o),
        .pc_o        (pc_o),
        .reg_write_o (reg_write_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .branch_o    (branch_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [15:0] addr;
        logic        full;
        logic        valid;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [31:0] imm;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [15:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic vec_t v(input logic [31:0] inst, input logic [15:0] addr,
                               input logic full, input logic valid, input logic [5:0] op,
                               input logic [4:0] rd, input logic [31:0] rs_d,
                               input logic [31:0] rt_d, input logic [31:0] imm,
                               input logic rw, input logic mr, input logic mw,
                               input logic br);
        vec_t r;
        r.inst = inst; r.addr = addr; r.full = full; r.valid = valid; r.op = op;
        r.rd = rd; r.rs_d = rs_d; r.rt_d = rt_d; r.imm = imm;
        r.rw = rw; r.mr = mr; r.mw = mw; r.br = br;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bundle(input string name, input vec_t e);
        chk({name, ".valid"}, {31'd0, valid_o}, {31'd0, e.valid});
        chk({name, ".op"}, {26'd0, op_o}, {26'd0, e.op});
        chk({name, ".ctrl"}, {28'd0, reg_write_o, mem_read_o, mem_write_o, branch_o},
            {28'd0, e.rw, e.mr, e.mw, e.br});
        if (e.full) begin
            chk({name, ".rd"}, {27'd0, rd_o}, {27'd0, e.rd});
            chk({name, ".rs_data"}, rs_data_o, e.rs_d);
            chk({name, ".rt_data"}, rt_data_o, e.rt_d);
            chk({name, ".imm"}, imm_o, e.imm);
            chk({name, ".pc"}, {16'd0, pc_o}, {16'd0, e.addr});
        end
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we_i = 1'b1; wb_addr_i = a; wb_data_i = d;
        step();
        wb_we_i = 1'b0;
    endtask

    initial begin
        vecs[0] = v(mk(6'h10, 5'd3, 5'd2, 16'hFFFF), 16'h0004, 1, 1, 6'h10, 5'd3,
                    32'h5, 32'h0, 32'hFFFF_FFFF, 1, 0, 0, 0);
        vecs[1] = v(mk(6'h01, 5'd7, 5'd5, 16'h3000), 16'h0008, 1, 1, 6'h01, 5'd7,
                    32'h1234_5678, 32'hA5A5_0000, 32'h0000_3000, 1, 0, 0, 0);
        vecs[2] = v(mk(6'h21, 5'd0, 5'd2, 16'h2810), 16'h000C, 1, 1, 6'h21, 5'd0,
                    32'h5, 32'h1234_5678, 32'h0000_2810, 0, 0, 1, 0);
        vecs[3] = v(mk(6'h30, 5'd0, 5'd2, 16'h37FC), 16'h0010, 1, 1, 6'h30, 5'd0,
                    32'h5, 32'hA5A5_0000, 32'h0000_37FC, 0, 0, 0, 1);
        vecs[4] = v(mk(6'h31, 5'd0, 5'd0, 16'h8000), 16'h0014, 1, 1, 6'h31, 5'd0,
                    32'h0, 32'h0, 32'h0000_8000, 0, 0, 0, 1);
        vecs[5] = v(mk(6'h1F, 5'd9, 5'd6, 16'h8001), 16'h0018, 1, 1, 6'h1F, 5'd9,
                    32'hA5A5_0000, 32'h0, 32'hFFFF_8001, 1, 0, 0, 0);
        vecs[6] = v(mk(6'h3F, 5'd1, 5'd2, 16'h0000), 16'h001C, 0, 0, 6'h00, 5'd0,
                    32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        vecs[7] = v(mk(6'h22, 5'd1, 5'd2, 16'h0000), 16'h0020, 0, 0, 6'h00, 5'd0,
                    32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        vecs[8] = v(mk(6'h20, 5'd4, 5'd2, 16'h0004), 16'h0024, 1, 1, 6'h20, 5'd4,
                    32'h5, 32'h0, 32'h0000_0004, 1, 1, 0, 0);

        rst = 1'b1; inst_i = 32'h0421_0000; inst_addr_i = 16'h00AA;
        stall_i = 1'b0; flush_i = 1'b0;
        wb_we_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
        #1;
        chk("reset.stall_comb", {31'd0, stall_o}, 32'd0);
        step();
        step();
        chk("reset.valid", {31'd0, valid_o}, 32'd0);
        chk("reset.pc", {16'd0, pc_o}, 32'd0);
        chk("reset.stall", {31'd0, stall_o}, 32'd0);
        chk("reset.imm", imm_o, 32'd0);
        chk("reset.rs_data", rs_data_o, 32'd0);
        rst = 1'b0;

        for (int i = 1; i < 32; i++) begin
            inst_i = mk(6'h01, 5'd0, i[4:0], {i[4:0], 11'h000});
            step();
            chk($sformatf("reset.reg%0d_a", i), rs_data_o, 32'd0);
            chk($sformatf("reset.reg%0d_b", i), rt_data_o, 32'd0);
        end

        inst_i = 32'h0000_0000;
        wb_write(5'd2, 32'h0000_0005);
        wb_write(5'd5, 32'h1234_5678);
        wb_write(5'd6, 32'hA5A5_0000);

        for (int i = 0; i < 9; i++) begin
            inst_i = vecs[i].inst;
            inst_addr_i = vecs[i].addr;
            #1;
            chk($sformatf("vec%0d.stall_pre", i), {31'd0, stall_o}, 32'd0);
            step();
            chk_bundle($sformatf("vec%0d", i), vecs[i]);
        end

        // Load-use right behind the LD from the last vector.
        inst_i = mk(6'h02, 5'd8, 5'd4, 16'h1000);
        inst_addr_i = 16'h0040;
        #1;
        chk("lu.stall_on", {31'd0, stall_o}, 32'd1);
        step();
        chk("lu.bubble_valid", {31'd0, valid_o}, 32'd0);
        chk("lu.bubble_ctrl", {28'd0, reg_write_o, mem_read_o, mem_write_o, branch_o}, 32'd0);
        chk("lu.stall_off", {31'd0, stall_o}, 32'd0);
        step();
        chk("lu.issue_valid", {31'd0, valid_o}, 32'd1);
        chk("lu.issue_op", {26'd0, op_o}, 32'h02);
        chk("lu.issue_pc", {16'd0, pc_o}, 32'h0040);
        chk("lu.issue_rt", rt_data_o, 32'h5);
        chk("lu.stall_after", {31'd0, stall_o}, 32'd0);

        wb_we_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'hDEAD_BEEF;
        inst_i = mk(6'h01, 5'd1, 5'd7, 16'h0000);
        inst_addr_i = 16'h0030;
        step();
        wb_we_i = 1'b0;
        chk("bypass.rs", rs_data_o, 32'hDEAD_BEEF);
        step();
        chk("bypass.stored", rs_data_o, 32'hDEAD_BEEF);
        wb_we_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'hFFFF_FFFF;
        inst_i = mk(6'h01, 5'd1, 5'd0, 16'h0000);
        step();
        wb_we_i = 1'b0;
        chk("r0.bypass", rs_data_o, 32'd0);
        step();
        chk("r0.stored", rs_data_o, 32'd0);

        inst_i = vecs[8].inst; inst_addr_i = vecs[8].addr;
        step();
        chk("flush.ld_mr", {31'd0, mem_read_o}, 32'd1);
        inst_i = mk(6'h02, 5'd8, 5'd4, 16'h1000);
        inst_addr_i = 16'h0044;
        stall_i = 1'b1; flush_i = 1'b1;
        #1;
        chk("flush.stall_comb", {31'd0, stall_o}, 32'd0);
        step();
        chk("flush.valid", {31'd0, valid_o}, 32'd0);
        chk("flush.mr", {31'd0, mem_read_o}, 32'd0);
        stall_i = 1'b0; flush_i = 1'b0;
        #1;
        chk("flush.stall_after", {31'd0, stall_o}, 32'd0);
        step();
        chk("flush.reissue", {31'd0, valid_o}, 32'd1);
        chk("flush.reissue_pc", {16'd0, pc_o}, 32'h0044);

        inst_i = vecs[0].inst; inst_addr_i = vecs[0].addr;
        step();
        chk_bundle("hold.pre", vecs[0]);
        stall_i = 1'b1;
        inst_i = mk(6'h21, 5'd0, 5'd5, 16'h3000);
        inst_addr_i = 16'h0050;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("hold%0d.stall", i), {31'd0, stall_o}, 32'd1);
            step();
            chk_bundle($sformatf("hold%0d", i), vecs[0]);
        end
        stall_i = 1'b0;
        step();
        chk("hold.release_mw", {31'd0, mem_write_o}, 32'd1);
        chk("hold.release_pc", {16'd0, pc_o}, 32'h0050);

        inst_i = vecs[8].inst; inst_addr_i = vecs[8].addr;
        step();
        inst_i = mk(6'h02, 5'd8, 5'd4, 16'h1000);
        stall_i = 1'b1;
        #1;
        chk("rststall.stall_before", {31'd0, stall_o}, 32'd1);
        rst = 1'b1;
        wb_we_i = 1'b1; wb_addr_i = 5'd2; wb_data_i = 32'h0000_0099;
        #1;
        chk("rststall.stall_comb", {31'd0, stall_o}, 32'd0);
        step();
        chk("rststall.valid", {31'd0, valid_o}, 32'd0);
        chk("rststall.pc", {16'd0, pc_o}, 32'd0);
        chk("rststall.rd", {27'd0, rd_o}, 32'd0);
        chk("rststall.imm", imm_o, 32'd0);
        chk("rststall.stall", {31'd0, stall_o}, 32'd0);
        rst = 1'b0; stall_i = 1'b0; wb_we_i = 1'b0;
        inst_i = mk(6'h01, 5'd1, 5'd2, 16'h2800);
        inst_addr_i = 16'h0060;
        step();
        chk("rststall.r2_cleared", rs_data_o, 32'd0);
        chk("rststall.r5_cleared", rt_data_o, 32'd0);
        chk("rststall.issue", {31'd0, valid_o}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
